// File: rtl/cipher_pkg.sv
// Shared types and default parameters for the frame cipher controller.
package cipher_pkg;

  localparam int unsigned NPIX_DEF   = 16384;
  localparam int unsigned ADDR_W_DEF = 14;
  localparam int unsigned WARMUP_DEF = 64;
  // Warmup counter width: holds up to 1023 discarded keystream words
  localparam int unsigned WU_W       = 10;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_WARMUP = 3'd1,
    ST_RUN    = 3'd2,
    ST_FLUSH  = 3'd3,
    ST_DONE   = 3'd4
  } state_t;

endpackage

// File: rtl/cipher_cnt.sv
// Enable/clear up-counter with a terminal-count flag at value LAST.
module cipher_cnt #(
  parameter int unsigned W    = 4,
  parameter int unsigned LAST = 15
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         clr,
  input  logic         en,
  output logic [W-1:0] cnt,
  output logic         tc_c
);

  // Count register; reset and clear both return to zero
  always_ff @(posedge clk) begin
    if (rst || clr) cnt <= '0;
    else if (en)    cnt <= cnt + W'(1);
  end

  assign tc_c = (cnt == W'(LAST));

endmodule

// File: rtl/cipher_ctrl.sv
// Frame cipher controller: discards WARMUP keystream words, then streams
// NPIX plaintext reads with matching ciphertext writes one cycle later.
// Optional build macro CIPHER_CTRL_ABORT_EN adds an abort input.
module cipher_ctrl
  import cipher_pkg::*;
#(
  parameter int unsigned NPIX   = NPIX_DEF,
  parameter int unsigned ADDR_W = ADDR_W_DEF,
  parameter int unsigned WARMUP = WARMUP_DEF
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              key_valid,
`ifdef CIPHER_CTRL_ABORT_EN
  input  logic              abort,
`endif
  output logic              key_take,
  output logic              rd_en,
  output logic [ADDR_W-1:0] rd_addr,
  output logic              wr_en,
  output logic [ADDR_W-1:0] wr_addr,
  output logic              busy,
  output logic              done
);

  localparam int unsigned WU_LAST = (WARMUP == 0) ? 0 : WARMUP - 1;
  localparam logic        WU_SKIP = (WARMUP == 0);

  state_t            state, state_nxt;
  logic              clr_c, wu_en_c, pix_en_c, abort_c;
  logic              wu_tc, pix_tc;
  logic [WU_W-1:0]   wu_cnt_unused;
  logic [ADDR_W-1:0] pix_cnt;

`ifdef CIPHER_CTRL_ABORT_EN
  assign abort_c = abort && busy;
`else
  assign abort_c = 1'b0;
`endif

  // Keystream words discarded before the first pixel
  cipher_cnt #(.W(WU_W), .LAST(WU_LAST)) u_wu_cnt (
    .clk  (clk),
    .rst  (rst),
    .clr  (clr_c),
    .en   (wu_en_c),
    .cnt  (wu_cnt_unused),
    .tc_c (wu_tc)
  );

  // Pixel issue counter, doubles as the read address
  cipher_cnt #(.W(ADDR_W), .LAST(NPIX - 1)) u_pix_cnt (
    .clk  (clk),
    .rst  (rst),
    .clr  (clr_c),
    .en   (pix_en_c),
    .cnt  (pix_cnt),
    .tc_c (pix_tc)
  );

  assign rd_addr = pix_cnt;

  // Next-state and handshake decode
  always_comb begin
    state_nxt = state;
    key_take  = 1'b0;
    rd_en     = 1'b0;
    clr_c     = 1'b0;
    wu_en_c   = 1'b0;
    pix_en_c  = 1'b0;
    case (state)
      ST_IDLE, ST_DONE: begin
        if (start) begin
          clr_c     = 1'b1;
          state_nxt = WU_SKIP ? ST_RUN : ST_WARMUP;
        end
      end
      ST_WARMUP: begin
        key_take = key_valid;
        wu_en_c  = key_valid;
        if (key_valid && wu_tc) state_nxt = ST_RUN;
      end
      ST_RUN: begin
        key_take = key_valid;
        rd_en    = key_valid;
        pix_en_c = key_valid;
        if (key_valid && pix_tc) state_nxt = ST_FLUSH;
      end
      ST_FLUSH: state_nxt = ST_DONE;
      default:  state_nxt = ST_IDLE;
    endcase
    // Abort kills the frame immediately, including this cycle's read
    if (abort_c) begin
      state_nxt = ST_IDLE;
      key_take  = 1'b0;
      rd_en     = 1'b0;
      wu_en_c   = 1'b0;
      pix_en_c  = 1'b0;
      clr_c     = 1'b1;
    end
  end

  // State, status flags and the one-cycle-delayed write strobe
  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= ST_IDLE;
      busy    <= 1'b0;
      done    <= 1'b0;
      wr_en   <= 1'b0;
      wr_addr <= '0;
    end else begin
      state   <= state_nxt;
      busy    <= (state_nxt == ST_WARMUP) || (state_nxt == ST_RUN) ||
                 (state_nxt == ST_FLUSH);
      done    <= (state_nxt == ST_DONE);
      wr_en   <= rd_en;
      wr_addr <= rd_addr;
    end
  end

endmodule

// File: doc/cipher_ctrl.md
CIPHER_CTRL -- requirements
Module: cipher_ctrl

Interface
REQ-001 SHALL have parameter NPIX, default 16384, meaning pixels per frame (power of two, 2..65536).
REQ-002 SHALL have parameter ADDR_W, default 14, meaning address width (log2 NPIX).
REQ-003 SHALL have parameter WARMUP, default 64, meaning keystream words discarded before the first pixel (0..1023).
REQ-004 SHALL have port clk, input, 1, meaning the single clock; all logic is on its rising edge.
REQ-005 SHALL have port rst, input, 1, meaning synchronous active-high reset.
REQ-006 SHALL have port start, input, 1, meaning a one-cycle frame request.
REQ-007 SHALL have port key_valid, input, 1, meaning the R/G/B keystream bytes from the CLFSR are valid this cycle.
REQ-008 SHALL have port key_take, output, 1, meaning consume the current keystream word.
REQ-009 SHALL have port rd_en, output, 1, meaning read the plaintext R/G/B memories.
REQ-010 SHALL have port rd_addr, output, ADDR_W, meaning the plaintext address.
REQ-011 SHALL have port wr_en, output, 1, meaning write the ciphertext R/G/B memories.
REQ-012 SHALL have port wr_addr, output, ADDR_W, meaning the ciphertext address.
REQ-013 SHALL have port busy, output, 1, meaning a frame is in progress.
REQ-014 SHALL have port done, output, 1, meaning the frame has completed (level).

Function
REQ-015 SHALL implement the states IDLE, WARMUP, RUN, FLUSH and DONE.
REQ-016 In IDLE or DONE, start SHALL move to WARMUP, clear done, and zero both counters; if WARMUP==0 it SHALL go directly to RUN.
REQ-017 In WARMUP, key_take SHALL equal key_valid; each accepted word SHALL increment the warmup count, and on the WARMUP-th accept the block SHALL go to RUN next cycle.
REQ-018 In RUN, rd_en and key_take SHALL both equal key_valid, and rd_addr SHALL be the pixel count; the count SHALL increment on each issue, and key_valid low SHALL stall it with no gaps skipped.
REQ-019 wr_en and wr_addr SHALL be rd_en and rd_addr delayed by exactly one cycle, matching one-cycle BRAM read latency; the datapath captures the key on key_take and adds it to the read data in the wr_en cycle.
REQ-020 Issuing address NPIX-1 SHALL move the block to FLUSH; in FLUSH, wr_en for NPIX-1 SHALL occur and the block SHALL enter DONE next cycle.
REQ-021 busy SHALL be 1 in WARMUP, RUN and FLUSH, and 0 otherwise.
REQ-022 done SHALL be 1 only in DONE and SHALL be held until start or rst.
REQ-023 start SHALL be ignored while busy.
REQ-024 Exactly NPIX writes SHALL occur per frame, to addresses 0..NPIX-1 in order, each exactly once, with no write at wrap.
REQ-025 key_take SHALL be 0 in IDLE, FLUSH and DONE.

Reset
REQ-026 rst SHALL take priority over all other inputs, including mid-frame.
REQ-027 rst SHALL force the state to IDLE, zero both counters, and drive key_take, rd_en, wr_en, busy and done to 0 and rd_addr and wr_addr to 0 in the following cycle; a pending delayed write SHALL be dropped.

Configuration
REQ-028 When CIPHER_CTRL_ABORT_EN is defined, the block SHALL add input abort (1 bit); abort while busy SHALL return the block to IDLE next cycle, suppress all further rd_en, wr_en and key_take (including the delayed write), and leave done at 0.
REQ-029 When CIPHER_CTRL_ABORT_EN is undefined, no abort port SHALL exist and behaviour SHALL be as above.

Structure
REQ-030 Shared package cipher_pkg SHALL hold the state enum typedef, NPIX and ADDR_W defaults, and the WARMUP default.
REQ-031 One sub-module, cipher_cnt, SHALL be used: a parameterised enable/clear up-counter with terminal-count flag, instantiated for the warmup count and the pixel count.

Verification
REQ-032 With NPIX=16, WARMUP=4, key_valid always 1, and start pulsed: the bench SHALL check 4 key_take cycles, then rd_addr 0..15 on consecutive cycles, wr_addr 0..15 one cycle later, done=1 at cycle 22 after start, and busy low.
REQ-033 With key_valid toggling 1/0 in RUN: the bench SHALL check that rd_en tracks key_valid, the address sequence stays contiguous, and total writes equal 16.
REQ-034 With WARMUP=0: the bench SHALL check that the first rd_en at addr 0 occurs in the cycle after start.
REQ-035 With rst asserted at pixel 7: the bench SHALL check all outputs are 0 the next cycle, no write to addr 7 occurs, and a new start runs a full frame from addr 0.
REQ-036 With start pulsed during RUN and again in DONE: the bench SHALL check the first start is ignored, and the second clears done and restarts WARMUP.
REQ-037 With CIPHER_CTRL_ABORT_EN defined and abort at pixel 5: the bench SHALL check IDLE the next cycle, that no wr_en for addr 5 occurs, and done=0.
